cast_unpack_op: RTL and testbench
=================================

Name: cast_unpack_op

Overview:
Sequential counterpart of the width-cast operators. Takes one wide operand and emits it as a stream of ReturnBitWidth-wide chunks, LSB chunk first, over a valid/ready handshake. A partial top chunk is padded by zero- or sign-extension. Used where the scheduler narrows wide values onto narrow datapaths or memory ports.

Parameters:
ParamOpCode, "zext", top-chunk padding mode: "zext" or "sext"; any other value pads with zeros.
ParamBitWidth, 32, width of input operand lhs.
ReturnBitWidth, 8, width of each output chunk ret; must be at least 1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  global stall; when low, no state changes and no handshake completes.
in_valid  input  1  lhs holds a valid operand.
in_ready  output  1  block accepts lhs this cycle.
lhs  input  ParamBitWidth  wide operand.
out_valid  output  1  ret holds a valid chunk.
out_ready  input  1  downstream accepts ret.
ret  output  ReturnBitWidth  current chunk.
out_last  output  1  ret is the final chunk of the operand.
out_idx  output  $clog2(NUM_CHUNKS+1)  chunk index of ret, 0-based.

Behaviour:
- NUM_CHUNKS = ceil(ParamBitWidth/ReturnBitWidth); PAD_W = NUM_CHUNKS*ReturnBitWidth.
- Operand is extended to PAD_W at load: sign bit lhs[ParamBitWidth-1] replicated for "sext", zeros otherwise. If PAD_W == ParamBitWidth, no padding.
- States: IDLE (no data held), SEND (shift register holds an operand).
- Accept: in_fire = in_valid & in_ready. in_ready = enable & (state==IDLE | (out_last & out_ready)).
- Emit: out_fire = out_valid & out_ready & enable. out_valid = (state==SEND). ret = low ReturnBitWidth bits of the shift register. out_last = (out_idx == NUM_CHUNKS-1).
- On out_fire without last: shift right by ReturnBitWidth, out_idx++.
- On out_fire with last: if in_fire in the same cycle, load new operand, out_idx=0, stay in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- IDLE + in_fire: load, out_idx=0, go to SEND. First chunk is valid the cycle after acceptance (latency 1).
- Throughput: one chunk per cycle; operands every NUM_CHUNKS cycles at full rate.
- NUM_CHUNKS==1: every operand produces one chunk with out_last=1.
- enable low: registers hold, in_ready=0, out_valid is unchanged, but no fire is counted.
- Reset (any time, including mid-operand): state=IDLE, out_valid=0, in_ready follows enable, ret=0, out_idx=0, out_last=0 (forced while IDLE). The partial operand is discarded.
- ret and out_idx are don't-care-stable while out_valid=0 but driven to 0 after reset.

Optional Feature:
CAST_UNPACK_MSB_FIRST_EN. When defined, chunks are emitted MSB chunk first: the padded top chunk is at index 0, and the register shifts left, with ret taken from the top ReturnBitWidth bits. When undefined, the order is LSB first as above. Handshake, out_idx and out_last semantics are identical in both cases.

Decomposition:
- Shared package cast_op_pkg:
  - opcode enum {CAST_ZEXT, CAST_SEXT, CAST_TRUNC} and a string-to-enum function.
  - function num_chunks(in_w, out_w).
  - state typedef {ST_IDLE, ST_SEND}.
- No sub-module: the datapath is one shift register plus a counter.

Test Plan:
- ParamBitWidth=20, ReturnBitWidth=8, "zext", lhs=0xA5C3F, out_ready=1 -> ret 0x3F, 0x5C, 0x0A on consecutive cycles; out_idx 0,1,2; out_last on the third beat only.
- Same operand with "sext" -> 0x3F, 0x5C, 0xFA. With lhs=0x25C3F -> 0x3F, 0x5C, 0x02.
- Two operands with in_valid held high, 0x12345678 then 0x9ABCDEF0 (32/8) -> 8 chunks on 8 consecutive cycles (78 56 34 12 F0 DE BC 9A) with no bubble; in_ready high only on the last beat of each operand.
- out_ready toggled 1,0,0,1,1 -> ret, out_idx and out_valid held stable while stalled; no chunk lost or duplicated.
- reset asserted after chunk index 1 of 0x12345678 -> out_valid=0 immediately (asynchronous). Next operand 0xCAFEBABE -> starts at index 0 with ret=0xBE.
- enable=0 for 3 cycles mid-stream -> no fire, state frozen; resumes at the same index. With CAST_UNPACK_MSB_FIRST_EN defined, 0x12345678 -> 12 34 56 78.

Source files
------------

// File: rtl/cast_op_pkg.sv
// Shared definitions for the width-cast operator family: opcode decode,
// chunk arithmetic and the unpacker state encoding.
package cast_op_pkg;

  typedef enum logic [1:0] {
    CAST_ZEXT  = 2'd0,
    CAST_SEXT  = 2'd1,
    CAST_TRUNC = 2'd2
  } cast_op_e;

  typedef logic [0:0] cast_state_t;

  localparam cast_state_t ST_IDLE = 1'b0;
  localparam cast_state_t ST_SEND = 1'b1;

  // Unrecognised opcode strings fall back to zero padding.
  function automatic cast_op_e str_to_op(input string s);
    if (s == "sext") return CAST_SEXT;
    if (s == "zext") return CAST_ZEXT;
    return CAST_TRUNC;
  endfunction

  function automatic int num_chunks(input int in_w, input int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/cast_unpack_op_if.sv
// Operand-in / chunk-out handshake bundle for cast_unpack_op.
interface cast_unpack_op_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  lhs;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ret;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;

  modport slave (
    input  in_valid, lhs, out_ready,
    output in_ready, out_valid, ret, out_last, out_idx
  );

  modport master (
    output in_valid, lhs, out_ready,
    input  in_ready, out_valid, ret, out_last, out_idx
  );
endinterface

// File: rtl/cast_unpack_op.sv
// Streams a wide operand out as ReturnBitWidth chunks, padded top chunk.
// Define CAST_UNPACK_MSB_FIRST_EN to emit the top chunk first.
module cast_unpack_op
  import cast_op_pkg::*;
#(
  parameter string ParamOpCode    = "zext",
  parameter int    ParamBitWidth  = 32,
  parameter int    ReturnBitWidth = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  cast_unpack_op_if.slave bus
);

  localparam int       NUM_CHUNKS = num_chunks(ParamBitWidth, ReturnBitWidth);
  localparam int       PAD_W      = NUM_CHUNKS * ReturnBitWidth;
  localparam int       IDX_W      = $clog2(NUM_CHUNKS + 1);
  localparam cast_op_e OPC        = str_to_op(ParamOpCode);
  localparam bit       SEXT       = (OPC == CAST_SEXT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  cast_state_t               r_state;
  logic [PAD_W-1:0]          r_shift;
  logic [IDX_W-1:0]          r_idx;

  logic                      w_send;
  logic                      w_last;
  logic                      w_in_ready;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic [PAD_W-1:0]          w_padded;
  logic [PAD_W-1:0]          w_shifted;
  logic [ReturnBitWidth-1:0] w_ret;

  assign w_send     = (r_state == ST_SEND);
  assign w_last     = w_send & (r_idx == LAST_IDX);
  assign w_in_ready = enable & (~w_send | (w_last & bus.out_ready));
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = w_send & bus.out_ready & enable;

  generate
    if (PAD_W == ParamBitWidth) begin : g_nopad
      assign w_padded = bus.lhs;
    end else begin : g_pad
      logic w_fill;
      assign w_fill   = SEXT & bus.lhs[ParamBitWidth-1];
      assign w_padded = {{(PAD_W - ParamBitWidth){w_fill}}, bus.lhs};
    end
  endgenerate

`ifdef CAST_UNPACK_MSB_FIRST_EN
  assign w_shifted = r_shift << ReturnBitWidth;
  assign w_ret     = r_shift[PAD_W-1 -: ReturnBitWidth];
`else
  assign w_shifted = r_shift >> ReturnBitWidth;
  assign w_ret     = r_shift[ReturnBitWidth-1:0];
`endif

  // in_ready in SEND implies the last chunk is firing, so a load also
  // retires the previous operand (back-to-back with no bubble).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else if (enable) begin
      if (w_in_fire) begin
        r_state <= ST_SEND;
        r_shift <= w_padded;
        r_idx   <= '0;
      end else if (w_out_fire) begin
        if (w_last) begin
          r_state <= ST_IDLE;
        end else begin
          r_shift <= w_shifted;
          r_idx   <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_send;
  assign bus.ret       = w_ret;
  assign bus.out_last  = w_last;
  assign bus.out_idx   = r_idx;

endmodule

// File: tb/tb_cast_unpack_op.sv
// Self-checking bench for cast_unpack_op: vector table on narrow configs,
// scoreboard on the 32/8 config with stall, reset and enable sequences.
module tb_cast_unpack_op;

`ifdef CAST_UNPACK_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk;
  logic reset;
  logic enable;

  int total;
  int bad;
  int n_fire_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cast_unpack_op_if #(.IN_W(20), .OUT_W(8), .IDX_W(2)) if_z ();
  cast_unpack_op_if #(.IN_W(20), .OUT_W(8), .IDX_W(2)) if_s ();
  cast_unpack_op_if #(.IN_W(5),  .OUT_W(8), .IDX_W(1)) if_1 ();
  cast_unpack_op_if #(.IN_W(32), .OUT_W(8), .IDX_W(3)) if_w ();

  cast_unpack_op #(.ParamOpCode("zext"), .ParamBitWidth(20), .ReturnBitWidth(8))
    u_z (.clk(clk), .reset(reset), .enable(enable), .bus(if_z.slave));
  cast_unpack_op #(.ParamOpCode("sext"), .ParamBitWidth(20), .ReturnBitWidth(8))
    u_s (.clk(clk), .reset(reset), .enable(enable), .bus(if_s.slave));
  cast_unpack_op #(.ParamOpCode("sext"), .ParamBitWidth(5), .ReturnBitWidth(8))
    u_1 (.clk(clk), .reset(reset), .enable(enable), .bus(if_1.slave));
  cast_unpack_op #(.ParamOpCode("zext"), .ParamBitWidth(32), .ReturnBitWidth(8))
    u_w (.clk(clk), .reset(reset), .enable(enable), .bus(if_w.slave));

  typedef struct packed {
    logic [19:0]      lhs;
    logic [2:0][7:0]  ez;
    logic [2:0][7:0]  es;
    logic [4:0]       l1;
    logic [7:0]       e1;
  } vec_t;

  typedef struct packed {
    logic [7:0] ret;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  vec_t  vecs[4];
  beat_t q_w[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] wide_chunk(input logic [31:0] v, input int k);
    int sel;
    sel = MSB ? (3 - k) : k;
    return v[8*sel +: 8];
  endfunction

  // Scoreboard and protocol monitor for the 32/8 instance, sampled mid-cycle.
  task automatic monitor_w();
    logic       stalled_prev;
    logic [7:0] saved_ret;
    logic [2:0] saved_idx;
    logic       exp_rdy;
    beat_t      b;
    stalled_prev = 1'b0;
    saved_ret    = '0;
    saved_idx    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q_w.delete();
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          chk("stall_valid", {31'd0, if_w.out_valid}, 32'd1);
          chk("stall_ret", {24'd0, if_w.ret}, {24'd0, saved_ret});
          chk("stall_idx", {29'd0, if_w.out_idx}, {29'd0, saved_idx});
        end
        stalled_prev = if_w.out_valid && !(if_w.out_ready && enable);
        saved_ret    = if_w.ret;
        saved_idx    = if_w.out_idx;
        exp_rdy = enable && (!if_w.out_valid || (if_w.out_last && if_w.out_ready));
        chk("in_ready_rule", {31'd0, if_w.in_ready}, {31'd0, exp_rdy});
        if (if_w.out_valid && if_w.out_ready && enable) begin
          n_fire_w++;
          if (q_w.size() == 0) begin
            chk("sb_unexpected_beat", {24'd0, if_w.ret}, 32'hFFFF_FFFF);
          end else begin
            b = q_w.pop_front();
            chk("sb_ret", {24'd0, if_w.ret}, {24'd0, b.ret});
            chk("sb_idx", {29'd0, if_w.out_idx}, {29'd0, b.idx});
            chk("sb_last", {31'd0, if_w.out_last}, {31'd0, b.last});
          end
        end
        if (if_w.in_valid && if_w.in_ready) begin
          for (int k = 0; k < 4; k++) begin
            b.ret  = wide_chunk(if_w.lhs, k);
            b.idx  = 3'(k);
            b.last = (k == 3);
            q_w.push_back(b);
          end
        end
      end
    end
  endtask

  task automatic send_w(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    if_w.lhs      = v;
    if_w.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_w.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if_w.in_valid = 1'b0;
  endtask

  task automatic drain_w();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (q_w.size() == 0 && !if_w.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [2:0] pat;
    int         c0;
    int         j;

    total = 0;
    bad = 0;
    n_fire_w = 0;

    vecs[0].lhs = 20'hA5C3F; vecs[0].ez = {8'h0A, 8'h5C, 8'h3F}; vecs[0].es = {8'hFA, 8'h5C, 8'h3F};
    vecs[0].l1 = 5'h13;      vecs[0].e1 = 8'hF3;
    vecs[1].lhs = 20'h25C3F; vecs[1].ez = {8'h02, 8'h5C, 8'h3F}; vecs[1].es = {8'h02, 8'h5C, 8'h3F};
    vecs[1].l1 = 5'h0A;      vecs[1].e1 = 8'h0A;
    vecs[2].lhs = 20'h80000; vecs[2].ez = {8'h08, 8'h00, 8'h00}; vecs[2].es = {8'hF8, 8'h00, 8'h00};
    vecs[2].l1 = 5'h10;      vecs[2].e1 = 8'hF0;
    vecs[3].lhs = 20'hFFFFF; vecs[3].ez = {8'h0F, 8'hFF, 8'hFF}; vecs[3].es = {8'hFF, 8'hFF, 8'hFF};
    vecs[3].l1 = 5'h0F;      vecs[3].e1 = 8'h0F;

    reset = 1'b1;
    enable = 1'b1;
    if_z.in_valid = 1'b0; if_z.lhs = '0; if_z.out_ready = 1'b1;
    if_s.in_valid = 1'b0; if_s.lhs = '0; if_s.out_ready = 1'b1;
    if_1.in_valid = 1'b0; if_1.lhs = '0; if_1.out_ready = 1'b1;
    if_w.in_valid = 1'b0; if_w.lhs = '0; if_w.out_ready = 1'b1;

    fork
      monitor_w();
    join_none

    #2;
    chk("rst_out_valid", {31'd0, if_w.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, if_w.in_ready}, 32'd1);
    chk("rst_ret", {24'd0, if_w.ret}, 32'd0);
    chk("rst_idx", {29'd0, if_w.out_idx}, 32'd0);
    chk("rst_last", {31'd0, if_w.out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Vector table on the 20/8 zext, 20/8 sext and single-chunk instances.
    for (int v = 0; v < 4; v++) begin
      if_z.lhs = vecs[v].lhs; if_z.in_valid = 1'b1;
      if_s.lhs = vecs[v].lhs; if_s.in_valid = 1'b1;
      if_1.lhs = vecs[v].l1;  if_1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if_z.in_valid = 1'b0;
      if_s.in_valid = 1'b0;
      if_1.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        j = MSB ? (2 - k) : k;
        chk("z_valid", {31'd0, if_z.out_valid}, 32'd1);
        chk("z_ret", {24'd0, if_z.ret}, {24'd0, vecs[v].ez[j]});
        chk("z_idx", {30'd0, if_z.out_idx}, k);
        chk("z_last", {31'd0, if_z.out_last}, {31'd0, (k == 2)});
        chk("s_ret", {24'd0, if_s.ret}, {24'd0, vecs[v].es[j]});
        chk("s_last", {31'd0, if_s.out_last}, {31'd0, (k == 2)});
        if (k == 0) begin
          chk("c1_ret", {24'd0, if_1.ret}, {24'd0, vecs[v].e1});
          chk("c1_last", {31'd0, if_1.out_last}, 32'd1);
          chk("c1_idx", {31'd0, if_1.out_idx}, 32'd0);
        end else if (k == 1) begin
          chk("c1_idle", {31'd0, if_1.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
      end
      chk("z_idle", {31'd0, if_z.out_valid}, 32'd0);
      chk("s_idle", {31'd0, if_s.out_valid}, 32'd0);
    end

    // Back-to-back operands: eight chunks on eight consecutive cycles.
    send_w(32'h12345678);
    c0 = n_fire_w;
    send_w(32'h9ABCDEF0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_beats", n_fire_w - c0, 32'd8);
    chk("b2b_idle", {31'd0, if_w.out_valid}, 32'd0);

    // Downstream stall pattern 1,0,0,1,1.
    pat = 3'b0;
    send_w(32'h0BADF00D);
    for (int p = 0; p < 5; p++) begin
      if_w.out_ready = (p == 1 || p == 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    if_w.out_ready = 1'b1;
    drain_w();

    // Asynchronous reset after chunk index 1 has been taken.
    send_w(32'h12345678);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if_w.out_valid}, 32'd0);
    chk("arst_ret", {24'd0, if_w.ret}, 32'd0);
    chk("arst_idx", {29'd0, if_w.out_idx}, 32'd0);
    chk("arst_last", {31'd0, if_w.out_last}, 32'd0);
    chk("arst_ready", {31'd0, if_w.in_ready}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_w(32'hCAFEBABE);
    chk("post_rst_valid", {31'd0, if_w.out_valid}, 32'd1);
    chk("post_rst_ret", {24'd0, if_w.ret}, MSB ? 32'hCA : 32'hBE);
    chk("post_rst_idx", {29'd0, if_w.out_idx}, 32'd0);
    drain_w();

    // Global stall for three cycles mid-operand.
    send_w(32'h55AA33CC);
    @(posedge clk);
    #1;
    enable = 1'b0;
    c0 = n_fire_w;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("en_idx_hold", {29'd0, if_w.out_idx}, 32'd1);
      chk("en_valid_hold", {31'd0, if_w.out_valid}, 32'd1);
      chk("en_ready_low", {31'd0, if_w.in_ready}, 32'd0);
    end
    chk("en_no_fire", n_fire_w - c0, 32'd0);
    enable = 1'b1;
    chk("en_resume_ret", {24'd0, if_w.ret}, {24'd0, wide_chunk(32'h55AA33CC, 1)});
    drain_w();

    chk("sb_empty", q_w.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
